// File: rtl/huff_pkg.sv
// huff_pkg: definitions shared by the Huffman merge scheduler.
//   state_e  - scheduler FSM states
//   clog2    - ceiling log2, never less than 1
//   id_w / slot_w / cnt_w - widths of record node ids, slot indices and
//   live-leaf counters, derived from the number of leaf symbols.
package huff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int MAX_NSYM = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Node ids cover NSYM leaves plus NSYM-1 internal parents.
  function automatic int id_w(input int nsym);
    return clog2(2 * nsym - 1);
  endfunction

  function automatic int slot_w(input int nsym);
    return clog2(nsym);
  endfunction

  function automatic int cnt_w(input int nsym);
    return clog2(nsym + 1);
  endfunction

endpackage

// File: rtl/huff_min2_select.sv
// huff_min2_select: combinational search for the two smallest live slots.
//   live_i  - live mask, one bit per slot
//   freq_i  - flattened slot frequencies, slot i at [i*FW +: FW]
//   min1_o  - live slot with the lowest frequency
//   min2_o  - lowest-frequency live slot other than min1_o
// Ties go to the lowest slot index: slots are scanned upward and only a
// strictly smaller frequency displaces an earlier candidate.
module huff_min2_select
  import huff_pkg::*;
#(
  parameter int NSYM = 10,
  parameter int FW   = 9,
  parameter int SW   = 4
) (
  input  logic [NSYM-1:0]    live_i,
  input  logic [NSYM*FW-1:0] freq_i,
  output logic [SW-1:0]      min1_o,
  output logic [SW-1:0]      min2_o
);

  logic          have1, have2;
  logic [FW-1:0] best1, best2, fr;

  always_comb begin
    min1_o = '0;
    min2_o = '0;
    have1  = 1'b0;
    have2  = 1'b0;
    best1  = '0;
    best2  = '0;
    fr     = '0;
    for (int i = 0; i < NSYM; i++) begin
      fr = freq_i[i*FW +: FW];
      if (live_i[i]) begin
        if (!have1 || fr < best1) begin
          // New minimum: previous minimum becomes the runner-up.
          min2_o = min1_o;
          best2  = best1;
          have2  = have1;
          min1_o = SW'(i);
          best1  = fr;
          have1  = 1'b1;
        end else if (!have2 || fr < best2) begin
          min2_o = SW'(i);
          best2  = fr;
          have2  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/huff_merge_sched.sv
// huff_merge_sched: schedules the merges of a Huffman tree build.
//   clk, rst          - clock, asynchronous active-high reset
//   start, freq_in    - load leaf frequencies and begin a build (IDLE only)
//   busy              - high whenever a build is in progress
//   merge_valid/ready - handshake for one merge record
//   merge_lo_id/hi_id - smallest and second-smallest child node ids
//   merge_parent_id   - id of the new parent node
//   merge_freq/sat    - parent frequency (saturating) and saturation flag
//   done, root_id     - end-of-build pulse and final root node id
module huff_merge_sched
  import huff_pkg::*;
#(
  parameter  int NSYM      = 10,
  parameter  int FW        = 9,
  parameter  int SKIP_ZERO = 1,
  localparam int IW        = id_w(NSYM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NSYM*FW-1:0] freq_in,
  output logic               busy,
  output logic               merge_valid,
  input  logic               merge_ready,
  output logic [IW-1:0]      merge_lo_id,
  output logic [IW-1:0]      merge_hi_id,
  output logic [IW-1:0]      merge_parent_id,
  output logic [FW-1:0]      merge_freq,
  output logic               merge_sat,
  output logic               done,
  output logic [IW-1:0]      root_id
);

  localparam int SW = slot_w(NSYM);
  localparam int CW = cnt_w(NSYM);

  state_e            state_q, state_d;
  logic [FW-1:0]     freq_q [NSYM];
  logic [FW-1:0]     freq_d [NSYM];
  logic [IW-1:0]     id_q   [NSYM];
  logic [IW-1:0]     id_d   [NSYM];
  logic [NSYM-1:0]   live_q, live_d;
  logic [IW-1:0]     next_parent_q, next_parent_d;
  logic [CW-1:0]     rem_q, rem_d;        // merges still to be issued
  logic [SW-1:0]     min1_q, min1_d, min2_q, min2_d;
  logic [IW-1:0]     root_q, root_d;

  logic [NSYM-1:0]   leaf_live;
  logic [NSYM*FW-1:0] freq_flat;
  logic [SW-1:0]     sel_min1, sel_min2;
  logic [CW-1:0]     k_load;
  logic [IW-1:0]     first_live;
  logic              found;
  logic [FW:0]       sum_w;
  logic              sat_w;

  for (genvar gi = 0; gi < NSYM; gi++) begin : g_slot
    assign leaf_live[gi] = (SKIP_ZERO != 0) ? (|freq_in[gi*FW +: FW]) : 1'b1;
    assign freq_flat[gi*FW +: FW] = freq_q[gi];
  end

  huff_min2_select #(.NSYM(NSYM), .FW(FW), .SW(SW)) u_select (
    .live_i (live_q),
    .freq_i (freq_flat),
    .min1_o (sel_min1),
    .min2_o (sel_min2)
  );

  // Live-leaf count and first live leaf of the incoming frequency vector;
  // the latter is the root when only one leaf survives.
  always_comb begin
    k_load     = '0;
    first_live = '0;
    found      = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      if (leaf_live[i]) begin
        k_load = k_load + CW'(1);
        if (!found) begin
          first_live = IW'(i);
          found      = 1'b1;
        end
      end
    end
  end

  assign sum_w      = {1'b0, freq_q[min1_q]} + {1'b0, freq_q[min2_q]};
  assign sat_w      = sum_w[FW];
  assign merge_freq = sat_w ? {FW{1'b1}} : sum_w[FW-1:0];

  assign busy            = (state_q != ST_IDLE);
  assign merge_valid     = (state_q == ST_EMIT);
  assign done            = (state_q == ST_DONE);
  assign merge_sat       = (state_q == ST_EMIT) && sat_w;
  assign merge_lo_id     = id_q[min1_q];
  assign merge_hi_id     = id_q[min2_q];
  assign merge_parent_id = next_parent_q;
  assign root_id         = root_q;

  always_comb begin
    state_d       = state_q;
    freq_d        = freq_q;
    id_d          = id_q;
    live_d        = live_q;
    next_parent_d = next_parent_q;
    rem_d         = rem_q;
    min1_d        = min1_q;
    min2_d        = min2_q;
    root_d        = root_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < NSYM; i++) begin
            freq_d[i] = freq_in[i*FW +: FW];
            id_d[i]   = IW'(i);
          end
          live_d        = leaf_live;
          next_parent_d = IW'(NSYM);
          if (k_load >= CW'(2)) begin
            rem_d   = k_load - CW'(1);
            state_d = ST_SELECT;
          end else begin
            root_d  = (k_load == '0) ? {IW{1'b1}} : first_live;
            state_d = ST_DONE;
          end
        end
      end
      ST_SELECT: begin
        min1_d  = sel_min1;
        min2_d  = sel_min2;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (merge_ready) begin
          // The parent takes over min1's slot; min2's slot is retired.
          freq_d[min1_q] = merge_freq;
          id_d[min1_q]   = next_parent_q;
          live_d[min2_q] = 1'b0;
          next_parent_d  = next_parent_q + IW'(1);
          if (rem_q == CW'(1)) begin
            root_d  = next_parent_q;
            state_d = ST_DONE;
          end else begin
            rem_d   = rem_q - CW'(1);
            state_d = ST_SELECT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < NSYM; i++) begin
        freq_q[i] <= '0;
        id_q[i]   <= '0;
      end
      live_q        <= '0;
      next_parent_q <= '0;
      rem_q         <= '0;
      min1_q        <= '0;
      min2_q        <= '0;
      root_q        <= '0;
    end else begin
      state_q       <= state_d;
      freq_q        <= freq_d;
      id_q          <= id_d;
      live_q        <= live_d;
      next_parent_q <= next_parent_d;
      rem_q         <= rem_d;
      min1_q        <= min1_d;
      min2_q        <= min2_d;
      root_q        <= root_d;
    end
  end

endmodule

// File: tb/tb_huff_merge_sched.sv
// Bench for huff_merge_sched: a 10-leaf instance (SKIP_ZERO=1) driven by a
// vector table, hand-written hold/start/reset sequences and randomized
// builds checked against a queue-based Huffman model; plus a 4-leaf
// instance (SKIP_ZERO=0) for the all-equal tie case.
module tb_huff_merge_sched;

  typedef struct packed {
    logic [4:0] lo;
    logic [4:0] hi;
    logic [4:0] par;
    logic [8:0] fr;
    logic       sat;
  } rec_t;

  typedef struct packed {
    logic [9:0][8:0] f;
    logic [4:0]      root;
    logic [3:0]      nrec;
    logic [3:0]      rbase;
  } vec_t;

  typedef struct {
    int slot;
    int id;
    int fr;
  } nd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start_a, ready_a, busy_a, valid_a, sat_a, done_a;
  logic [89:0] freq_a;
  logic [4:0]  lo_a, hi_a, par_a, root_a;
  logic [8:0]  mf_a;

  logic        start_b, ready_b, busy_b, valid_b, sat_b, done_b;
  logic [35:0] freq_b;
  logic [2:0]  lo_b, hi_b, par_b, root_b;
  logic [8:0]  mf_b;

  huff_merge_sched #(.NSYM(10), .FW(9), .SKIP_ZERO(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .freq_in(freq_a), .busy(busy_a),
    .merge_valid(valid_a), .merge_ready(ready_a), .merge_lo_id(lo_a),
    .merge_hi_id(hi_a), .merge_parent_id(par_a), .merge_freq(mf_a),
    .merge_sat(sat_a), .done(done_a), .root_id(root_a)
  );

  huff_merge_sched #(.NSYM(4), .FW(9), .SKIP_ZERO(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .freq_in(freq_b), .busy(busy_b),
    .merge_valid(valid_b), .merge_ready(ready_b), .merge_lo_id(lo_b),
    .merge_hi_id(hi_b), .merge_parent_id(par_b), .merge_freq(mf_b),
    .merge_sat(sat_b), .done(done_b), .root_id(root_b)
  );

  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  int   got_root, exp_root, first_v, done_c;
  vec_t vecs[4];
  rec_t rtab[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic rec_t cur_a();
    rec_t r;
    r.lo = lo_a; r.hi = hi_a; r.par = par_a; r.fr = mf_a; r.sat = sat_a;
    return r;
  endfunction

  function automatic rec_t mk(input int lo, input int hi, input int par, input int fr, input int sat);
    rec_t r;
    r.lo = 5'(lo); r.hi = 5'(hi); r.par = 5'(par); r.fr = 9'(fr); r.sat = (sat != 0);
    return r;
  endfunction

  function automatic logic [89:0] pk(input int a[10]);
    logic [89:0] f;
    for (int i = 0; i < 10; i++) f[i*9 +: 9] = 9'(a[i]);
    return f;
  endfunction

  // Reference: repeatedly combine the two cheapest live nodes (ties to the
  // lower slot); the parent reuses the cheaper node's slot.
  function automatic void model(input logic [89:0] f);
    nd_t nodes[$];
    nd_t n;
    int  a, b, s, np;
    rec_t r;
    exp_q.delete();
    np = 10;
    for (int i = 0; i < 10; i++) begin
      n.slot = i; n.id = i; n.fr = int'(f[i*9 +: 9]);
      if (n.fr != 0) nodes.push_back(n);
    end
    exp_root = 31;
    while (nodes.size() > 1) begin
      a = 0;
      for (int j = 1; j < nodes.size(); j++) if (nodes[j].fr < nodes[a].fr) a = j;
      b = -1;
      for (int j = 0; j < nodes.size(); j++)
        if (j != a && (b < 0 || nodes[j].fr < nodes[b].fr)) b = j;
      s = nodes[a].fr + nodes[b].fr;
      r = mk(nodes[a].id, nodes[b].id, np, (s > 511) ? 511 : s, (s > 511) ? 1 : 0);
      exp_q.push_back(r);
      nodes[a].id = np;
      nodes[a].fr = (s > 511) ? 511 : s;
      nodes.delete(b);
      np++;
    end
    if (nodes.size() == 1) exp_root = nodes[0].id;
  endfunction

  function automatic void load_exp(input int v);
    exp_q.delete();
    for (int i = 0; i < int'(vecs[v].nrec); i++) exp_q.push_back(rtab[int'(vecs[v].rbase) + i]);
    exp_root = int'(vecs[v].root);
  endfunction

  task automatic cmp_recs(input string tag);
    chk({tag, "_rec_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_r%0d_lo", tag, i),  32'(got_q[i].lo),  32'(exp_q[i].lo));
      chk($sformatf("%s_r%0d_hi", tag, i),  32'(got_q[i].hi),  32'(exp_q[i].hi));
      chk($sformatf("%s_r%0d_par", tag, i), 32'(got_q[i].par), 32'(exp_q[i].par));
      chk($sformatf("%s_r%0d_fr", tag, i),  32'(got_q[i].fr),  32'(exp_q[i].fr));
      chk($sformatf("%s_r%0d_sat", tag, i), 32'(got_q[i].sat), 32'(exp_q[i].sat));
    end
    chk({tag, "_root"}, 32'(got_root), 32'(exp_root));
  endtask

  // mode 0: ready always high; 1: random ready; 2: stall first record for
  // five cycles while pulsing start; 3: assert rst in the third EMIT.
  task automatic run_a(input logic [89:0] f, input int mode);
    int   cyc, nv;
    rec_t held;
    got_q.delete();
    got_root = -1; first_v = -1; done_c = -1; nv = 0;
    @(negedge clk);
    freq_a = f; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    freq_a = {26'($urandom), $urandom, $urandom};
    cyc = 1;
    while (cyc < 400) begin
      ready_a = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_a && first_v < 0) first_v = cyc;
      if (mode == 2 && valid_a && nv == 0) begin
        held = cur_a();
        ready_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
          start_a = (k == 1 || k == 3);
          @(negedge clk);
          cyc++;
          chk("hold_valid", 32'(valid_a), 32'd1);
          chk("hold_stable", 32'(cur_a()), 32'(held));
        end
        start_a = 1'b0;
        ready_a = 1'b1;
      end
      if (mode == 3 && valid_a && nv == 2) begin
        rst = 1'b1;
        #1;
        chk("rst_async_busy", 32'(busy_a), 32'd0);
        chk("rst_async_valid", 32'(valid_a), 32'd0);
        chk("rst_async_done", 32'(done_a), 32'd0);
        return;
      end
      if (valid_a && ready_a) begin
        got_q.push_back(cur_a());
        nv++;
      end
      if (done_a) begin
        done_c = cyc;
        got_root = int'(root_a);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("build_done_seen", 32'(done_c >= 0), 32'd1);
    if (done_c >= 0) begin
      @(negedge clk);
      chk("done_one_cycle", 32'(done_a), 32'd0);
      chk("idle_after_done", 32'(busy_a), 32'd0);
      chk("root_held", 32'(root_a), 32'(got_root));
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_busy"},  32'(busy_a),  32'd0);
    chk({tag, "_valid"}, 32'(valid_a), 32'd0);
    chk({tag, "_done"},  32'(done_a),  32'd0);
    chk({tag, "_sat"},   32'(sat_a),   32'd0);
    chk({tag, "_lo"},    32'(lo_a),    32'd0);
    chk({tag, "_hi"},    32'(hi_a),    32'd0);
    chk({tag, "_par"},   32'(par_a),   32'd0);
    chk({tag, "_freq"},  32'(mf_a),    32'd0);
    chk({tag, "_root"},  32'(root_a),  32'd0);
  endtask

  task automatic rand_build(input int n);
    logic [89:0] f;
    int sel;
    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       f[i*9 +: 9] = 9'd0;
        1:       f[i*9 +: 9] = 9'($urandom_range(1, 20));
        2:       f[i*9 +: 9] = 9'($urandom_range(200, 511));
        default: f[i*9 +: 9] = 9'($urandom_range(0, 511));
      endcase
    end
    model(f);
    run_a(f, 1);
    cmp_recs($sformatf("rand%0d", n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, tot_cnt);
    $fatal(1);
  end

  initial begin
    int t[10];
    int b_exp[3][4];
    int nb, cyc;

    t = '{5, 9, 12, 13, 16, 45, 0, 0, 0, 0};
    vecs[0] = '{f: pk(t), root: 5'd14, nrec: 4'd5, rbase: 4'd0};
    t = '{511, 300, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{f: pk(t), root: 5'd10, nrec: 4'd1, rbase: 4'd5};
    t = '{0, 0, 0, 0, 0, 0, 0, 7, 0, 0};
    vecs[2] = '{f: pk(t), root: 5'd7, nrec: 4'd0, rbase: 4'd0};
    t = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{f: pk(t), root: 5'd31, nrec: 4'd0, rbase: 4'd0};
    rtab[0] = mk(0, 1, 10, 14, 0);
    rtab[1] = mk(2, 3, 11, 25, 0);
    rtab[2] = mk(10, 4, 12, 30, 0);
    rtab[3] = mk(11, 12, 13, 55, 0);
    rtab[4] = mk(5, 13, 14, 100, 0);
    rtab[5] = mk(1, 0, 10, 511, 1);
    b_exp = '{'{0, 1, 4, 2}, '{2, 3, 5, 2}, '{4, 5, 6, 4}};

    rst = 1'b1; start_a = 1'b0; ready_a = 1'b0; freq_a = '0;
    start_b = 1'b0; ready_b = 1'b0; freq_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_a("reset");
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      load_exp(v);
      run_a(vecs[v].f, 0);
      cmp_recs($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_done_latency", v), 32'(done_c), 32'(2 * int'(vecs[v].nrec) + 1));
      if (vecs[v].nrec != 0) chk($sformatf("vec%0d_first_valid", v), 32'(first_v), 32'd2);
    end

    load_exp(0);
    run_a(vecs[0].f, 2);
    cmp_recs("stall");

    run_a(vecs[0].f, 3);
    @(negedge clk);
    chk_reset_a("midrst");
    rst = 1'b0;
    load_exp(0);
    run_a(vecs[0].f, 0);
    cmp_recs("after_rst");

    for (int n = 0; n < 30; n++) rand_build(n);

    // 4-leaf all-equal build: ties must resolve to the lowest slot.
    @(negedge clk);
    freq_b = {9'd1, 9'd1, 9'd1, 9'd1};
    start_b = 1'b1;
    ready_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    nb = 0;
    cyc = 0;
    while (cyc < 100 && !done_b) begin
      if (valid_b) begin
        if (nb < 3) begin
          chk($sformatf("tie_r%0d_lo", nb),  32'(lo_b),  32'(b_exp[nb][0]));
          chk($sformatf("tie_r%0d_hi", nb),  32'(hi_b),  32'(b_exp[nb][1]));
          chk($sformatf("tie_r%0d_par", nb), 32'(par_b), 32'(b_exp[nb][2]));
          chk($sformatf("tie_r%0d_fr", nb),  32'(mf_b),  32'(b_exp[nb][3]));
        end
        nb++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("tie_done_seen", 32'(done_b), 32'd1);
    chk("tie_rec_count", 32'(nb), 32'd3);
    chk("tie_root", 32'(root_b), 32'd6);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
